branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor for a 5-stage in-order pipeline: direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- FETCH looks up the PC combinationally and gets a predicted next PC.
- DECODE allocates or refreshes entries for branches.
- EXECUTE outcome, arriving one cycle after decode, trains the counter.

Parameters:
- ENTRIES, 16, number of BTB entries; must be a power of two, at least 2.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- f_pc  in  ADDR_W  PC of the instruction currently in FETCH.
- d_pc  in  ADDR_W  PC of the instruction currently in DECODE.
- d_is_branch  in  1  DECODE instruction is a branch.
- d_target_addr  in  ADDR_W  DECODE-computed branch target; meaningful only when d_is_branch=1.
- x_predict_res  in  1  actual outcome (1=taken) of the branch that was in DECODE the previous cycle.
- f_predict_addr  out  ADDR_W  predicted next fetch PC.
- f_predict_valid  out  1  1 = predicted taken, redirect fetch to f_predict_addr.

Behaviour:
- Indexing:
  - IW = log2(ENTRIES); index = pc[IW+1:2]; tag = pc[ADDR_W-1:IW+2]; pc[1:0] ignored.
  - Entry = {valid, tag, target[ADDR_W-1:0], ctr[1:0]}.
- Fetch (combinational, zero latency):
  - hit = valid[idx(f_pc)] & tag match.
  - f_predict_valid = hit & ctr[1].
  - f_predict_addr = target when f_predict_valid, else f_pc+4 (modulo 2^ADDR_W wrap).
  - Lookup sees table contents as of the last clock edge; no same-cycle forwarding unless the optional feature is enabled.
- Decode (written at rising edge when d_is_branch=1):
  - Hit on d_pc: target <= d_target_addr; ctr unchanged.
  - Miss, or different tag (replacement): valid<=1, tag<=tag(d_pc), target<=d_target_addr, ctr<=2'b01 (weakly not-taken).
- Execute stage register (internal): x_pc<=d_pc and x_br<=d_is_branch on every edge.
- Training (when x_br=1 and entry at idx(x_pc) is valid with matching tag):
  - x_predict_res=1: ctr saturating +1, max 2'b11.
  - x_predict_res=0: ctr saturating -1, min 2'b00.
  - Tag mismatch (entry evicted): training dropped silently.
  - x_predict_res ignored when x_br=0.
- Same-index collision in one cycle:
  - Decode allocation of a different tag wins; the training update is dropped.
  - Decode hit on the same entry: training applies to ctr, decode refreshes target; both take effect.
- Reset (rst=1 at edge):
  - All valid bits cleared; x_br<=0.
  - Tag/target/ctr contents don't-care.
  - Inputs ignored that cycle, including d_is_branch and training.
  - During and after reset, f_predict_valid=0 and f_predict_addr=f_pc+4 until an entry is allocated and trained to taken.
  - Mid-operation reset discards any pending training.
- No handshakes; every input is sampled every cycle. Implement the table in flops (async read).

Optional Feature:
- Macro BP_FWD_EN.
- Defined: if d_is_branch=1 and idx(d_pc)==idx(f_pc) and tag(d_pc)==tag(f_pc) in the same cycle, the fetch lookup uses the entry as it will be written:
  - Target = d_target_addr.
  - ctr = existing ctr on hit, 2'b01 on new allocation.
  - Same-cycle training is not forwarded.
- Undefined: fetch sees only registered contents.
- Table update rules are identical in both cases.

Test Plan:
- Reset, then f_pc=0x1008 for 4 cycles -> f_predict_valid=0, f_predict_addr=0x100C every cycle.
- Decode d_pc=0x1014, target=0x1000; next cycle x_predict_res=1 -> ctr=2'b10; then f_pc=0x1014 -> f_predict_valid=1, f_predict_addr=0x1000.
- Decode d_pc=0x1008, target=0x1010; next cycle x_predict_res=0 -> ctr=2'b00; f_pc=0x1008 -> f_predict_valid=0, addr=0x100C. Repeat not-taken training -> ctr stays 2'b00.
- Train 0x100C to taken 3 times -> ctr=2'b11; one not-taken -> 2'b10, still predicts 0x1014; second not-taken -> 2'b01, valid=0.
- ENTRIES=16, 0x1014 trained taken; decode 0x1054 (same index 5, different tag) target 0x2000 -> f_pc=0x1014 predicts not-taken, addr 0x1018; f_pc=0x1054 misses training, ctr=2'b01, valid=0.
- Trained-taken entry present; assert rst one cycle, concurrently d_is_branch=1 -> afterwards every lookup returns f_predict_valid=0, f_predict_addr=f_pc+4.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch lookup,
// decode-time allocate/refresh, execute-time training. Optional macro BP_FWD_EN.
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] f_pc,
   input  logic [ADDR_W-1:0] d_pc,
   input  logic              d_is_branch,
   input  logic [ADDR_W-1:0] d_target_addr,
   input  logic              x_predict_res,
   output logic [ADDR_W-1:0] f_predict_addr,
   output logic              f_predict_valid
);

   localparam int IW = $clog2(ENTRIES);
   localparam int TW = ADDR_W - IW - 2;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TW-1:0]      tag_q    [ENTRIES];
   logic [TW-1:0]      tag_d    [ENTRIES];
   logic [ADDR_W-1:0]  target_q [ENTRIES];
   logic [ADDR_W-1:0]  target_d [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [1:0]         ctr_d    [ENTRIES];

   // Execute stage keeps only the word address; byte offset never matters.
   logic [ADDR_W-1:2]  x_pc_q, x_pc_d;
   logic               x_br_q, x_br_d;

   logic [IW-1:0]      f_idx, d_idx, x_idx;
   logic [TW-1:0]      f_tag, d_tag, x_tag;
   logic               d_hit, x_hit;

   logic               lk_valid;
   logic [ADDR_W-1:0]  lk_target;
   logic [1:0]         lk_ctr;

   logic               unused_pc_lsbs;

   assign unused_pc_lsbs = ^{f_pc[1:0], d_pc[1:0]};

   assign f_idx = f_pc[IW+1:2];
   assign f_tag = f_pc[ADDR_W-1:IW+2];
   assign d_idx = d_pc[IW+1:2];
   assign d_tag = d_pc[ADDR_W-1:IW+2];
   assign x_idx = x_pc_q[IW+1:2];
   assign x_tag = x_pc_q[ADDR_W-1:IW+2];

   assign d_hit = valid_q[d_idx] && (tag_q[d_idx] == d_tag);
   assign x_hit = valid_q[x_idx] && (tag_q[x_idx] == x_tag);

   // Training first, then decode; a decode allocation overwrites the counter,
   // while a decode hit leaves the freshly trained counter alone.
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;

      if (x_br_q && x_hit) begin
         if (x_predict_res) begin
            if (ctr_q[x_idx] != 2'b11) ctr_d[x_idx] = ctr_q[x_idx] + 2'd1;
         end else begin
            if (ctr_q[x_idx] != 2'b00) ctr_d[x_idx] = ctr_q[x_idx] - 2'd1;
         end
      end

      if (d_is_branch) begin
         target_d[d_idx] = d_target_addr;
         if (!d_hit) begin
            valid_d[d_idx] = 1'b1;
            tag_d[d_idx]   = d_tag;
            ctr_d[d_idx]   = 2'b01;
         end
      end

      x_pc_d = d_pc[ADDR_W-1:2];
      x_br_d = d_is_branch;
   end

   always_comb begin
      lk_valid  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
      lk_target = target_q[f_idx];
      lk_ctr    = ctr_q[f_idx];
`ifdef BP_FWD_EN
      // Bypass the entry decode is about to write; training is not bypassed.
      if (d_is_branch && (d_idx == f_idx) && (d_tag == f_tag)) begin
         lk_valid  = 1'b1;
         lk_target = d_target_addr;
         lk_ctr    = d_hit ? ctr_q[d_idx] : 2'b01;
      end
`endif
      f_predict_valid = !rst && lk_valid && lk_ctr[1];
      f_predict_addr  = f_predict_valid ? lk_target : f_pc + ADDR_W'(4);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         x_br_q  <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         ctr_q    <= ctr_d;
         x_pc_q   <= x_pc_d;
         x_br_q   <= x_br_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed + randomized check of branch_predictor against a behavioural BTB model.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] f_pc, d_pc, d_target_addr;
   logic        d_is_branch, x_predict_res;
   logic [31:0] f_predict_addr;
   logic        f_predict_valid;

   int compared   = 0;
   int mismatched = 0;

   typedef struct packed {
      logic        v;
      logic [31:0] a;
   } exp_t;
   exp_t exp_q[$];

   bit          mvalid [16];
   logic [31:0] mtag   [16];
   logic [31:0] mtgt   [16];
   logic [1:0]  mctr   [16];
   logic [31:0] mxpc;
   bit          mxbr;

   branch_predictor #(.ENTRIES(16), .ADDR_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .f_pc           (f_pc),
      .d_pc           (d_pc),
      .d_is_branch    (d_is_branch),
      .d_target_addr  (d_target_addr),
      .x_predict_res  (x_predict_res),
      .f_predict_addr (f_predict_addr),
      .f_predict_valid(f_predict_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, compared=%0d", compared);
      $fatal(1, "timeout");
   end

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % 16);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] pc);
      return pc >> 6;
   endfunction

   function automatic exp_t predict(input logic r, input logic [31:0] f, input logic br,
                                    input logic [31:0] dp, input logic [31:0] dt);
      exp_t e;
      int   i = idx_of(f);
      bit   hit = mvalid[i] && (mtag[i] == tag_of(f));
      logic [31:0] tgt = mtgt[i];
      logic [1:0]  c   = mctr[i];
`ifdef BP_FWD_EN
      if (br && idx_of(dp) == i && tag_of(dp) == tag_of(f)) begin
         tgt = dt;
         c   = hit ? mctr[i] : 2'b01;
         hit = 1'b1;
      end
`endif
      e.v = !r && hit && c[1];
      e.a = e.v ? tgt : f + 32'd4;
      return e;
   endfunction

   task automatic model_edge(input logic r, input logic br, input logic [31:0] dp,
                             input logic [31:0] dt, input logic xr);
      int  xi = idx_of(mxpc);
      int  di = idx_of(dp);
      bit  dhit;
      if (r) begin
         for (int k = 0; k < 16; k++) mvalid[k] = 1'b0;
         mxbr = 1'b0;
         return;
      end
      dhit = mvalid[di] && (mtag[di] == tag_of(dp));
      if (mxbr && mvalid[xi] && mtag[xi] == tag_of(mxpc)) begin
         if (xr && mctr[xi] < 2'd3) mctr[xi] = mctr[xi] + 2'd1;
         else if (!xr && mctr[xi] > 2'd0) mctr[xi] = mctr[xi] - 2'd1;
      end
      if (br) begin
         mtgt[di] = dt;
         if (!dhit) begin
            mvalid[di] = 1'b1;
            mtag[di]   = tag_of(dp);
            mctr[di]   = 2'b01;
         end
      end
      mxpc = dp;
      mxbr = br;
   endtask

   task automatic step(input string tag, input logic r, input logic [31:0] f,
                       input logic br, input logic [31:0] dp, input logic [31:0] dt,
                       input logic xr);
      exp_t e;
      rst = r; f_pc = f; d_is_branch = br; d_pc = dp; d_target_addr = dt; x_predict_res = xr;
      exp_q.push_back(predict(r, f, br, dp, dt));
      @(negedge clk);
      e = exp_q.pop_front();
      compared++;
      assert (f_predict_valid === e.v) else begin
         mismatched++;
         $error("FAIL %s valid f_pc=%h got=%b exp=%b", tag, f, f_predict_valid, e.v);
      end
      compared++;
      assert (f_predict_addr === e.a) else begin
         mismatched++;
         $error("FAIL %s addr f_pc=%h got=%h exp=%h", tag, f, f_predict_addr, e.a);
      end
      @(posedge clk);
      model_edge(r, br, dp, dt, xr);
      #1;
   endtask

   initial begin
      logic [31:0] pa, pb, tg;
      mxbr = 1'b0;
      mxpc = '0;
      for (int k = 0; k < 16; k++) begin
         mvalid[k] = 1'b0; mtag[k] = '0; mtgt[k] = '0; mctr[k] = '0;
      end

      step("rst0", 1, 32'h1008, 0, 0, 0, 0);
      step("rst1", 1, 32'h1008, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) step("idle", 0, 32'h1008, 0, 0, 0, 0);

      // Allocate 0x1014 and train it taken once.
      step("alloc14", 0, 32'h1014, 1, 32'h1014, 32'h1000, 0);
      step("wk_nt14", 0, 32'h1014, 0, 0, 0, 1);
      step("taken14", 0, 32'h1014, 0, 0, 0, 0);

      // 0x1008 trained not-taken twice, saturates at 00.
      step("alloc08", 0, 32'h1008, 1, 32'h1008, 32'h1010, 0);
      step("nt08a", 0, 32'h1008, 1, 32'h1008, 32'h1010, 0);
      step("nt08b", 0, 32'h1008, 0, 0, 0, 0);
      step("nt08c", 0, 32'h1008, 0, 0, 0, 0);

      // 0x100C trained taken three times, then walked back down.
      step("alloc0c", 0, 32'h100C, 1, 32'h100C, 32'h1014, 0);
      step("tk0c_1", 0, 32'h100C, 1, 32'h100C, 32'h1014, 1);
      step("tk0c_2", 0, 32'h100C, 1, 32'h100C, 32'h1014, 1);
      step("tk0c_3", 0, 32'h100C, 0, 0, 0, 1);
      step("sat0c", 0, 32'h100C, 1, 32'h100C, 32'h1014, 0);
      step("dn0c_1", 0, 32'h100C, 1, 32'h100C, 32'h1014, 0);
      step("dn0c_2", 0, 32'h100C, 0, 0, 0, 0);
      step("wk0c", 0, 32'h100C, 0, 0, 0, 0);

      // Same index 5, different tag: replacement kills the taken entry.
      step("pre14", 0, 32'h1014, 1, 32'h1054, 32'h2000, 0);
      step("evict14", 0, 32'h1014, 0, 0, 0, 1);
      step("new54", 0, 32'h1054, 0, 0, 0, 0);

      // Collision: allocation of other tag while training the old one.
      step("re14", 0, 32'h1054, 1, 32'h1014, 32'h1000, 0);
      step("tr14", 0, 32'h1014, 1, 32'h1054, 32'h2000, 1);
      step("col54", 0, 32'h1014, 0, 0, 0, 1);
      step("col54b", 0, 32'h1054, 0, 0, 0, 0);

      // Decode hit plus training on the same entry: both take effect.
      step("h54a", 0, 32'h1054, 1, 32'h1054, 32'h2000, 0);
      step("h54b", 0, 32'h1054, 1, 32'h1054, 32'h2100, 1);
      step("h54c", 0, 32'h1054, 0, 0, 0, 1);
      step("h54d", 0, 32'h1054, 0, 0, 0, 0);

      // Reset with a decode pending and a trained-taken entry present.
      step("prerst", 0, 32'h1054, 1, 32'h1054, 32'h2200, 0);
      step("rstbr", 1, 32'h1054, 1, 32'h1054, 32'h2200, 1);
      step("postrst", 0, 32'h1054, 0, 0, 0, 1);
      step("postrst2", 0, 32'h1014, 0, 0, 0, 0);
      step("wrap", 0, 32'hFFFF_FFFC, 0, 0, 0, 0);

      // Randomized phase over a small PC pool to force collisions.
      for (int n = 0; n < 400; n++) begin
         pa = {20'h00001, 6'($urandom_range(0, 3) * 16 + 6'($urandom_range(0, 3))), 2'b00} << 0;
         pa = 32'h1000 | (32'($urandom_range(0, 1)) << 6) | (32'($urandom_range(0, 3)) << 2);
         pb = 32'h1000 | (32'($urandom_range(0, 1)) << 6) | (32'($urandom_range(0, 3)) << 2);
         tg = 32'h8000 + (32'($urandom_range(0, 255)) << 2);
         step("rand", ($urandom_range(0, 39) == 0), pa, 1'($urandom_range(0, 1)), pb, tg,
              1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
